board_wt200b_i2s_tx: RTL

Stereo I2S transmitter for the WT200B board audio DAC, clocked from the 21.48 MHz clock-divider output (`CLK_21M`). Accepts 16-bit left/right PCM frames from the sound mixer through a valid/ready handshake into a 4-entry FIFO. Serialises them as I2S with `DAC_BCLK`, `DAC_LRCK` and `DAC_SDATA` generated by integer division, so no fractional clock divider is needed in the audio path. Flags FIFO underrun and emits a per-frame strobe so the producer can pace itself.

---
 rtl/board_wt200b_i2s_tx.sv | 86 ++++++++
 1 files changed

// File: rtl/board_wt200b_i2s_tx.sv
// board_wt200b_i2s_tx: FIFO-buffered stereo I2S transmitter with integer BCLK divider.
module board_wt200b_i2s_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int BCLK_HALF  = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [SAMPLE_W-1:0]           IN_LEFT,
  input  logic [SAMPLE_W-1:0]           IN_RIGHT,
  input  logic                          UNDERRUN_CLR,
  output logic                          DAC_BCLK,
  output logic                          DAC_LRCK,
  output logic                          DAC_SDATA,
  output logic                          FRAME_TICK,
  output logic                          UNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * SAMPLE_W;
  localparam int SW = $clog2(FW);
  localparam int DW = $clog2(BCLK_HALF + 1);
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [DW-1:0] div_q;
  logic [SW-1:0] slot_q, slot_d, idx;
  logic [FW-1:0] frame_q, frame_d;
  logic          bclk_q, lrck_q, sdata_q, tick_q, und_q;
  logic          wrap, fall, load, empty, push, pop;
  assign empty      = lvl_q == '0;
  assign IN_READY   = lvl_q != LW'(FIFO_DEPTH);
  assign wrap       = div_q == DW'(BCLK_HALF - 1);
  assign fall       = wrap && bclk_q;
  assign load       = fall && slot_q == SW'(FW - 1);
  assign push       = IN_VALID && IN_READY;
  assign pop        = load && !empty;
  assign DAC_BCLK   = bclk_q;
  assign DAC_LRCK   = lrck_q;
  assign DAC_SDATA  = sdata_q;
  assign FRAME_TICK = tick_q;
  assign UNDERRUN   = und_q;
  assign FIFO_LEVEL = lvl_q;
  // {L,R} packed MSB-first makes the serial bit frame[2W-1-slot] for both channels
  always_comb begin
    slot_d  = load ? '0 : slot_q + 1'b1;
    frame_d = pop ? mem_q[rd_q] : frame_q;
    idx     = SW'(FW - 1) - slot_d;
    lvl_d   = lvl_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= SW'(FW - 1);
      frame_q <= '0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      tick_q  <= 1'b0;
      und_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
    end else begin
      div_q  <= wrap ? '0 : div_q + 1'b1;
      bclk_q <= bclk_q ^ wrap;
      tick_q <= load;
      und_q  <= (load && empty) || (und_q && !UNDERRUN_CLR);
      lvl_q  <= lvl_d;
      if (fall) begin
        slot_q  <= slot_d;
        frame_q <= frame_d;
        sdata_q <= frame_d[idx];
        lrck_q  <= slot_d >= SW'(SAMPLE_W - 1) && slot_d <= SW'(FW - 2);
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (push && !RESET) mem_q[wr_q] <= {IN_LEFT, IN_RIGHT};
  end
endmodule
